lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 53 +++++
 rtl/lsu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// ----------------------------------------------------------------------------
// lsu_if -- signal bundle between the execute stage, the LSU and data memory.
//
// Request side (execute -> LSU):
//   req_valid, req_ready, req_we, req_size[1:0], req_unsigned,
//   req_addr[31:0], req_wdata[31:0]
// Memory side (LSU <-> data memory):
//   mem_req, mem_we, mem_addr[31:0], mem_be[3:0], mem_wdata[31:0],
//   mem_ack, mem_rdata[31:0]
// Response side (LSU -> writeback):
//   resp_valid, resp_rdata[31:0], resp_misaligned
//
// Modports:
//   slave  -- the LSU itself
//   master -- the environment around it (execute stage + memory)
// ----------------------------------------------------------------------------
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output resp_valid, resp_rdata, resp_misaligned
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu -- load/store unit for a single-issue in-order core.
//
// Accepts one memory operation at a time from the execute stage, issues a
// word-aligned access with byte enables to data memory, waits (unbounded)
// for the acknowledge, and returns a one-cycle response carrying the
// sign/zero-extended load data. Misaligned or illegal-size accesses never
// reach memory; they complete the cycle after acceptance with
// resp_misaligned set.
//
// Ports:
//   clk  -- sole clock, rising-edge
//   rst  -- synchronous, active-high reset
//   bus  -- lsu_if.slave: request, memory and response signal groups
// ----------------------------------------------------------------------------
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Registered copy of the accepted request.
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    // Response payload, loaded on acceptance (errors) or on mem_ack (loads).
    logic [31:0] resp_data_q;
    logic        resp_mis_q;

    logic        accept;
    logic        req_bad;
    logic        in_wait;
    logic        in_resp;
    logic [3:0]  be_lanes;
    logic [31:0] wdata_lanes;
    logic [31:0] load_data;

    assign in_wait = (state == WAIT);
    assign in_resp = (state == RESP);

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    // Illegal size, or an address not a multiple of the access size.
    always_comb begin
        case (bus.req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = (bus.req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_bad ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response payload
    // ------------------------------------------------------------------
    // rst wins over both an accept and an ack landing on the same edge,
    // since it is tested first.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_we       <= 1'b0;
            op_size     <= 2'b00;
            op_unsigned <= 1'b0;
            op_addr     <= 32'd0;
            op_wdata    <= 32'd0;
            resp_data_q <= 32'd0;
            resp_mis_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_we       <= bus.req_we;
                op_size     <= bus.req_size;
                op_unsigned <= bus.req_unsigned;
                op_addr     <= bus.req_addr;
                op_wdata    <= bus.req_wdata;
                resp_data_q <= 32'd0;
                resp_mis_q  <= req_bad;
            end
            if (in_wait && bus.mem_ack) begin
                resp_data_q <= op_we ? 32'd0 : load_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store lane steering: byte enables plus data replicated across lanes,
    // so memory can pick the enabled bytes without knowing the offset.
    // ------------------------------------------------------------------
    always_comb begin
        be_lanes    = 4'b1111;
        wdata_lanes = op_wdata;
        case (op_size)
            2'b00: begin
                be_lanes    = 4'b0001 << op_addr[1:0];
                wdata_lanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be_lanes    = 4'b0011 << {op_addr[1], 1'b0};
                wdata_lanes = {2{op_wdata[15:0]}};
            end
            default: begin
                be_lanes    = 4'b1111;
                wdata_lanes = op_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction: pick the addressed lane, then extend.
    // ------------------------------------------------------------------
    logic [31:0] rdata_shifted;
    logic [15:0] ld_half;
    logic        ext_bit;

    always_comb begin
        rdata_shifted = bus.mem_rdata >> {op_addr[1:0], 3'b000};
        ld_half       = op_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ext_bit       = 1'b0;
        load_data     = bus.mem_rdata;
        case (op_size)
            2'b00: begin
                ext_bit   = ~op_unsigned & rdata_shifted[7];
                load_data = {{24{ext_bit}}, rdata_shifted[7:0]};
            end
            2'b01: begin
                ext_bit   = ~op_unsigned & ld_half[15];
                load_data = {{16{ext_bit}}, ld_half};
            end
            default: load_data = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: memory bus is driven only while an access is outstanding,
    // and is all-zero otherwise.
    // ------------------------------------------------------------------
    assign bus.mem_req   = in_wait;
    assign bus.mem_we    = in_wait && op_we;
    assign bus.mem_addr  = in_wait ? {op_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_be    = (in_wait && op_we) ? be_lanes : 4'b0000;
    assign bus.mem_wdata = (in_wait && op_we) ? wdata_lanes : 32'd0;

    assign bus.resp_valid      = in_resp;
    assign bus.resp_rdata      = in_resp ? resp_data_q : 32'd0;
    assign bus.resp_misaligned = in_resp && resp_mis_q;

endmodule
